// File: rtl/sd_pkg.sv
// Shared types and constants for the standard-deviation UART output stage.
// The header value is also used by the host-side packet decoder model.
package sd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int         PKT_BYTES      = 4;
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    function automatic logic [7:0] pkt_checksum(input logic [7:0] hdr, input logic [15:0] value);
        return hdr ^ value[15:8] ^ value[7:0];
    endfunction

endpackage

// File: rtl/sd_uart_tx_if.sv
// Valid/ready handshake carrying one 16-bit standard-deviation result per frame.
interface sd_uart_tx_if;
    logic        sd_valid;
    logic [15:0] sd_data;
    logic        sd_ready;

    modport master (output sd_valid, output sd_data, input  sd_ready);
    modport slave  (input  sd_valid, input  sd_data, output sd_ready);
endinterface

// File: rtl/uart_byte_tx.sv
// UART 8N1 byte serializer. A start accepted in the last stop-bit cycle chains
// the next byte with no idle gap between frames.
module uart_byte_tx
    import sd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 417
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       idle
);

    localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       data_q;
    logic             bit_end;
    logic             load;

    assign bit_end = (baud_cnt == CNT_LAST);
    assign load    = start && (state_q == IDLE || done);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // The baud counter restarts on every bit boundary, so no error accumulates across bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            if (state_q == IDLE || bit_end) baud_cnt <= '0;
            else                            baud_cnt <= baud_cnt + 1'b1;
            if (state_q == DATA && bit_end) bit_idx <= bit_idx + 1'b1;
        end
    end

    // NOTE: the byte register needs no reset; it is always written before it is shifted out.
    always_ff @(posedge clk) begin
        if (load) data_q <= data;
    end

    // NOTE: every branch starts from a default assignment so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start)                  state_d = START;
            START: if (bit_end)                state_d = DATA;
            DATA:  if (bit_end && &bit_idx)    state_d = STOP;
            STOP:  if (bit_end)                state_d = start ? START : IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        done = 1'b0;
        idle = 1'b0;
        case (state_q)
            IDLE:    idle = 1'b1;
            START:   tx   = 1'b0;
            DATA:    tx   = data_q[bit_idx];
            STOP:    done = bit_end;
            default: idle = 1'b0;
        endcase
    end

endmodule

// File: rtl/sd_uart_tx.sv
// Packs each standard-deviation result as header, high, low, checksum and
// streams the four bytes back-to-back over a UART 8N1 line.
module sd_uart_tx
    import sd_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 417,
    parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
    input  logic         clk,
    input  logic         rstn,
    sd_uart_tx_if.slave  sd,
    output logic         tx,
    output logic         busy,
    output logic         pkt_done
);

    if (CLKS_PER_BIT < 2) begin : g_bad_cfg
        $fatal(1, "sd_uart_tx: CLKS_PER_BIT must be at least 2");
    end

    logic [1:0]  byte_idx;
    logic [23:0] rest_q;
    logic        byte_start;
    logic [7:0]  byte_data;
    logic        byte_done;
    logic        byte_idle;
    logic        accept;
    logic        last_byte;

    assign accept     = sd.sd_valid && byte_idle;
    assign last_byte  = (byte_idx == 2'(PKT_BYTES - 1));
    assign byte_start = accept || (byte_done && !last_byte);
    assign byte_data  = accept ? HEADER : rest_q[23:16];

    assign sd.sd_ready = byte_idle;
    assign busy        = !byte_idle;

    // Remaining payload bytes queue up behind the header; sd_data is not looked at again.
    always_ff @(posedge clk) begin
        if (accept)
            rest_q <= {sd.sd_data[15:8], sd.sd_data[7:0], pkt_checksum(HEADER, sd.sd_data)};
        else if (byte_start)
            rest_q <= {rest_q[15:0], 8'h00};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_idx <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= byte_done && last_byte;
            if (accept)         byte_idx <= '0;
            else if (byte_done) byte_idx <= byte_idx + 1'b1;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk   (clk),
        .rstn  (rstn),
        .start (byte_start),
        .data  (byte_data),
        .tx    (tx),
        .done  (byte_done),
        .idle  (byte_idle)
    );

endmodule

// File: tb/tb_sd_uart_tx.sv
// Bench for sd_uart_tx: a waveform-level packet model checked every cycle, a
// serial decoder, and directed scenarios with hand-computed packet bytes.
module tb_sd_uart_tx;
    import sd_pkg::*;

    localparam int C = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic tx, busy, pkt_done;

    sd_uart_tx_if sd_if ();

    sd_uart_tx #(.CLKS_PER_BIT(C), .HEADER(HEADER_DEFAULT)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sd       (sd_if),
        .tx       (tx),
        .busy     (busy),
        .pkt_done (pkt_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted result becomes a list of 160 line levels, one per cycle.
    bit   wave[$];
    logic m_tx = 1'b1, m_ready = 1'b1, m_busy = 1'b0, m_done = 1'b0;
    bit   m_fin = 1'b0;

    task automatic push_byte(input logic [7:0] b);
        repeat (C) wave.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (C) wave.push_back(b[i]);
        repeat (C) wave.push_back(1'b1);
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wave.delete();
            m_tx = 1'b1; m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_fin = 1'b0;
        end else begin
            if (m_ready && sd_if.sd_valid) begin
                push_byte(HEADER_DEFAULT);
                push_byte(sd_if.sd_data[15:8]);
                push_byte(sd_if.sd_data[7:0]);
                push_byte(HEADER_DEFAULT ^ sd_if.sd_data[15:8] ^ sd_if.sd_data[7:0]);
            end
            if (wave.size() > 0) begin
                m_tx = wave.pop_front();
                m_busy = 1'b1; m_ready = 1'b0; m_done = 1'b0;
                m_fin = (wave.size() == 0);
            end else begin
                m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b1;
                m_done = m_fin; m_fin = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("tx", tx, m_tx);
        check("sd_ready", sd_if.sd_ready, m_ready);
        check("busy", busy, m_busy);
        check("pkt_done", pkt_done, m_done);
    end

    // Host-side decoder: finds a start bit, then samples mid-bit.
    logic [7:0] rx_q[$];
    int fr_err = 0;
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rstn && tx === 1'b0) begin
                repeat (C / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = tx;
                end
                repeat (C) @(negedge clk);
                if (tx !== 1'b1) fr_err++;
                rx_q.push_back(b);
            end
        end
    end

    task automatic send(input logic [15:0] d);
        @(negedge clk);
        sd_if.sd_valid = 1'b1;
        sd_if.sd_data  = d;
        @(negedge clk);
        sd_if.sd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (pkt_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, pkt_done, 1'b1);
    endtask

    task automatic check_pkt(input string name, input logic [31:0] exp);
        int n = 0;
        logic [7:0] got;
        while (rx_q.size() < 4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
            check($sformatf("%s_byte%0d", name, i), got, exp[31 - 8 * i -: 8]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges, lat;
        logic prev;
        sd_if.sd_valid = 1'b0;
        sd_if.sd_data  = 16'h0000;

        // Reset state and quiet line after release
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_ready", sd_if.sd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_pkt_done", pkt_done, 1'b0);
        rstn  = 1'b1;
        edges = 0;
        prev  = tx;
        repeat (100) begin
            @(negedge clk);
            if (tx !== prev) edges++;
            prev = tx;
        end
        check("idle_tx_edges", edges, 0);

        // Single packet and pkt_done latency
        send(16'h1234);
        lat = 1;
        while (pkt_done !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        check("pkt_done_latency", lat, 161);
        check_pkt("p1234", 32'hA5123483);

        // New requests while busy are ignored
        send(16'h1234);
        repeat (19) @(negedge clk);
        sd_if.sd_valid = 1'b1;
        sd_if.sd_data  = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("ready_while_busy", sd_if.sd_ready, 1'b0);
        end
        sd_if.sd_valid = 1'b0;
        wait_done("busy_pkt_done_timeout");
        check_pkt("busy1234", 32'hA5123483);
        repeat (10) @(negedge clk);
        check("no_extra_bytes", rx_q.size(), 0);

        // Back-to-back packets with valid held high
        @(negedge clk);
        sd_if.sd_valid = 1'b1;
        sd_if.sd_data  = 16'h0000;
        @(negedge clk);
        sd_if.sd_data  = 16'h00FF;
        wait_done("b2b_first_timeout");
        @(negedge clk);
        check("b2b_start_bit", tx, 1'b0);
        sd_if.sd_valid = 1'b0;
        wait_done("b2b_second_timeout");
        check_pkt("p0000", 32'hA50000A5);
        check_pkt("p00ff", 32'hA500FF5A);

        // Asynchronous reset in byte2 bit3, then a clean packet
        send(16'h5670);
        repeat (96) @(negedge clk);
        check("pre_reset_tx", tx, 1'b0);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_tx", tx, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_ready", sd_if.sd_ready, 1'b1);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (60) @(negedge clk);
        rx_q.delete();
        send(16'hBEEF);
        wait_done("beef_timeout");
        check_pkt("pbeef", 32'hA5BEEFF4);

        // Top-bit / bottom-bit payload
        send(16'h8001);
        wait_done("p8001_timeout");
        check_pkt("p8001", 32'hA5800124);

        repeat (5) @(negedge clk);
        check("framing_errors", fr_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
